// File: rtl/riscv_core_sequencer.sv
// riscv_core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for a single-cycle RV32 datapath
module riscv_core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  input  logic        Zero,
  input  logic [31:0] BranchTarget,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MEMRead,
  output logic        MEMwrite,
  output logic        MEMToReg,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic        retire,
  output logic [31:0] retire_count,
  output logic        halt,
  output logic [1:0]  fault_code
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [7:0] LAST = 8'(DMEM_TIMEOUT - 1);
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic [1:0] fault_nxt;
  logic is_r, is_i, is_ld, is_st, is_beq, legal, taken, bad_target, timeout, dp_phase;
  logic rw_d, as_d, mr_d, mw_d, mtr_d, br_d, dv_d, ret_d, halt_d;
  logic [1:0] aop_d;
  assign is_r = instruction[6:0] == 7'b0110011;
  assign is_i = instruction[6:0] == 7'b0010011;
  assign is_ld = instruction[6:0] == 7'b0000011;
  assign is_st = instruction[6:0] == 7'b0100011;
  assign is_beq = instruction[6:0] == 7'b1100011 && instruction[14:12] == 3'b000;
  assign legal = is_r || is_i || is_ld || is_st || is_beq;
  assign taken = Branch && Zero;
  assign bad_target = taken && BranchTarget[1:0] != 2'b00;
  assign timeout = cnt == LAST;
  assign imem_req = state == FETCH && !reset;
  assign imem_addr = PC;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_nxt;
  // next-state and fault selection
  always_comb begin
    state_nxt = state;
    fault_nxt = fault_code;
    case (state)
      FETCH: state_nxt = imem_ready ? DECODE : FETCH;
      DECODE: begin
        state_nxt = legal ? EXEC : HALT;
        fault_nxt = legal ? fault_code : 2'd1;
      end
      EXEC: state_nxt = (is_ld || is_st) ? MEM : WB;
      MEM: begin
        state_nxt = dmem_ready ? WB : timeout ? HALT : MEM;
        fault_nxt = (!dmem_ready && timeout) ? 2'd2 : fault_code;
      end
      WB: begin
        state_nxt = bad_target ? HALT : FETCH;
        fault_nxt = bad_target ? 2'd3 : fault_code;
      end
      default: state_nxt = HALT;
    endcase
  end
  // control values for the cycle being entered, so outputs come straight from flops
  always_comb begin
    dp_phase = state_nxt == EXEC || state_nxt == MEM || state_nxt == WB;
    as_d = dp_phase && (is_i || is_ld || is_st);
    mtr_d = dp_phase && is_ld;
    br_d = dp_phase && is_beq;
    aop_d = !dp_phase ? 2'b00 : is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
    mr_d = state_nxt == MEM && is_ld;
    mw_d = state_nxt == MEM && is_st;
    dv_d = state_nxt == MEM;
    rw_d = state_nxt == WB && (is_r || is_i || is_ld);
    ret_d = state == WB && state_nxt == FETCH;
    halt_d = state_nxt == HALT;
  end
  // registered datapath controls and status
  always_ff @(posedge clk or posedge reset)
    if (reset) {RegWrite, ALUSrc, MEMRead, MEMwrite, MEMToReg, Branch, ALUOp, dmem_valid, retire, halt} <= '0;
    else {RegWrite, ALUSrc, MEMRead, MEMwrite, MEMToReg, Branch, ALUOp, dmem_valid, retire, halt} <=
      {rw_d, as_d, mr_d, mw_d, mtr_d, br_d, aop_d, dv_d, ret_d, halt_d};
  // IR, PC commit, retire counter, fault latch and MEM timeout counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      PC <= RESET_PC;
      instruction <= 32'h0000_0013;
      retire_count <= '0;
      fault_code <= '0;
      cnt <= '0;
    end else begin
      fault_code <= fault_nxt;
      cnt <= state == MEM ? cnt + 8'd1 : 8'd0;
      if (state == FETCH && imem_ready) instruction <= imem_rdata;
      if (state == WB && !bad_target) begin
        PC <= taken ? BranchTarget : PC + 32'd4;
        retire_count <= retire_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_riscv_core_sequencer.sv
// tb_riscv_core_sequencer: per-instruction expected traces checked every cycle against the sequencer
module tb_riscv_core_sequencer;
  logic clk = 0, reset, imem_req, imem_ready, Zero, dmem_valid, dmem_ready, retire, halt;
  logic RegWrite, ALUSrc, MEMRead, MEMwrite, MEMToReg, Branch;
  logic [1:0] ALUOp, fault_code;
  logic [31:0] imem_addr, imem_rdata, instruction, PC, BranchTarget, retire_count;
  typedef struct packed {
    logic req, rw, as, mr, mw, mtr, br;
    logic [1:0] aop;
    logic dv, ret, hlt;
    logic [1:0] fc;
    logic [31:0] pc, rc;
  } exp_t;
  typedef struct {string nm; logic [31:0] act; logic [31:0] exp;} lit_t;
  exp_t exp_q[$];
  lit_t lit_q[$];
  exp_t got, want;
  lit_t l;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_rc;
  logic m_ret;
  riscv_core_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instruction(instruction), .PC(PC), .Zero(Zero), .BranchTarget(BranchTarget),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MEMRead(MEMRead), .MEMwrite(MEMwrite), .MEMToReg(MEMToReg),
    .Branch(Branch), .ALUOp(ALUOp), .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .retire(retire),
    .retire_count(retire_count), .halt(halt), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      got = {imem_req, RegWrite, ALUSrc, MEMRead, MEMwrite, MEMToReg, Branch, ALUOp, dmem_valid, retire, halt,
             fault_code, PC, retire_count};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL trace t=%0t got=%h want=%h", $time, got, want);
      end
    end
    while (lit_q.size() != 0) begin
      l = lit_q.pop_front();
      checks++;
      if (l.act !== l.exp) begin
        errors++;
        $display("FAIL %s got=%h want=%h", l.nm, l.act, l.exp);
      end
    end
  end
  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] e);
    lit_q.push_back('{nm, a, e});
  endtask
  task automatic do_reset();
    reset = 1;
    dmem_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_pc = 0;
    m_rc = 0;
    m_ret = 0;
  endtask
  task automatic halt_trace(inout exp_t t[$], input logic [1:0] code, input int nhalt);
    exp_t e;
    e = '0;
    e.hlt = 1;
    e.fc = code;
    e.pc = m_pc;
    e.rc = m_rc;
    repeat (nhalt) t.push_back(e);
    m_ret = 0;
  endtask
  task automatic run(input logic [31:0] ins, input logic z, input logic [31:0] bt, input int iw, input int w,
                     input int nhalt, input int lim);
    exp_t t[$];
    exp_t e;
    bit r, i, ld, st, beq, legal, mem, tk;
    int n;
    r = ins[6:0] == 7'h33;
    i = ins[6:0] == 7'h13;
    ld = ins[6:0] == 7'h03;
    st = ins[6:0] == 7'h23;
    beq = ins[6:0] == 7'h63 && ins[14:12] == 3'd0;
    legal = r || i || ld || st || beq;
    mem = ld || st;
    e = '0;
    e.pc = m_pc;
    e.rc = m_rc;
    for (int k = 0; k <= iw; k++) begin
      e.req = 1;
      e.ret = k == 0 && m_ret;
      t.push_back(e);
    end
    e.req = 0;
    e.ret = 0;
    t.push_back(e);
    if (!legal) halt_trace(t, 2'd1, nhalt);
    else begin
      e.as = i || ld || st;
      e.mtr = ld;
      e.br = beq;
      e.aop = r ? 2'b10 : beq ? 2'b01 : 2'b00;
      t.push_back(e);
      if (mem) begin
        e.mr = ld;
        e.mw = st;
        e.dv = 1;
        repeat (w < 0 ? 255 : w + 1) t.push_back(e);
        e.mr = 0;
        e.mw = 0;
        e.dv = 0;
      end
      if (mem && w < 0) halt_trace(t, 2'd2, nhalt);
      else begin
        e.rw = r || i || ld;
        t.push_back(e);
        tk = beq && z;
        if (tk && bt[1:0] != 2'b00) halt_trace(t, 2'd3, nhalt);
        else begin
          m_pc = tk ? bt : m_pc + 32'd4;
          m_rc = m_rc + 32'd1;
          m_ret = 1;
        end
      end
    end
    n = (lim > 0 && lim < t.size()) ? lim : t.size();
    for (int k = 0; k < n; k++) exp_q.push_back(t[k]);
    imem_rdata = ins;
    Zero = z;
    BranchTarget = bt;
    for (int c = 1; c <= n; c++) begin
      imem_ready = c > iw;
      dmem_ready = mem && w >= 0 && c == iw + 4 + w;
      @(posedge clk);
      #1;
    end
    dmem_ready = 0;
  endtask
  initial begin
    reset = 1;
    imem_ready = 1;
    imem_rdata = 32'h002081B3;
    Zero = 0;
    BranchTarget = 0;
    dmem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pin("rst_ctl", 32'({imem_req, RegWrite, ALUSrc, MEMRead, MEMwrite, MEMToReg, Branch, ALUOp, dmem_valid, retire,
                        halt, fault_code}), 32'd0);
    pin("rst_pc", PC, 32'd0);
    pin("rst_ir", instruction, 32'h13);
    pin("rst_rc", retire_count, 32'd0);
    @(posedge clk);
    #1 reset = 0;
    m_pc = 0;
    m_rc = 0;
    m_ret = 0;
    run(32'h002081B3, 0, 0, 0, 0, 0, 0);
    pin("add_pc", PC, 32'd4);
    pin("add_rc", retire_count, 32'd1);
    pin("add_ret", 32'(retire), 32'd1);
    run(32'h0000A183, 0, 0, 0, 3, 0, 0);
    pin("ld_pc", PC, 32'd8);
    pin("ld_rc", retire_count, 32'd2);
    run(32'h00000063, 1, 32'h40, 0, 0, 0, 0);
    pin("beq_t_pc", PC, 32'h40);
    run(32'h00000063, 0, 32'h80, 0, 0, 0, 0);
    pin("beq_nt_pc", PC, 32'h44);
    run(32'h00100093, 0, 0, 2, 0, 0, 0);
    pin("addi_pc", PC, 32'h48);
    run(32'h0020A023, 0, 0, 0, 254, 0, 0);
    pin("st255_pc", PC, 32'h4C);
    pin("st255_halt", 32'(halt), 32'd0);
    run(32'h0020A023, 0, 0, 0, -1, 4, 0);
    pin("to_fc", 32'(fault_code), 32'd2);
    pin("to_halt", 32'(halt), 32'd1);
    do_reset();
    run(32'h0000007F, 0, 0, 0, 0, 5, 0);
    pin("ill_fc", 32'(fault_code), 32'd1);
    pin("ill_req", 32'(imem_req), 32'd0);
    do_reset();
    run(32'h00000063, 1, 32'h42, 0, 0, 4, 0);
    pin("mis_fc", 32'(fault_code), 32'd3);
    pin("mis_pc", PC, 32'd0);
    pin("mis_rc", retire_count, 32'd0);
    do_reset();
    run(32'h0000A183, 0, 0, 0, -1, 0, 5);
    pin("mem_dv", 32'(dmem_valid), 32'd1);
    pin("mem_rd", 32'(MEMRead), 32'd1);
    reset = 1;
    #1;
    pin("arst_dv", 32'(dmem_valid), 32'd0);
    pin("arst_rd", 32'(MEMRead), 32'd0);
    pin("arst_req", 32'(imem_req), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
